// File: rtl/pll_seq_pkg.sv
// Shared state encoding and widths for the PLL lock sequencer.
// Frequency-check defaults are only present when PLL_FREQ_CHECK_EN is defined.
package pll_seq_pkg;

    localparam int RETRIES_W = 4;
    localparam int STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_PLLRST   = 3'd0,
        S_WAITLOCK = 3'd1,
        S_STABLE   = 3'd2,
        S_RUN      = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

`ifdef PLL_FREQ_CHECK_EN
    localparam int FREQ_WINDOW_DEF = 1024;
    localparam int EXP_EDGES_DEF   = 160;
    localparam int FREQ_TOL_DEF    = 4;
`endif

endpackage

// File: rtl/pll_seq_sync.sv
// Multi-flop synchronizer with synchronous reset for signals crossing into CLKI.
module pll_seq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: drives PLLRST, qualifies LOCK, releases the core reset.
// Optional CLKOP frequency check is enabled with the PLL_FREQ_CHECK_EN macro.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 10000,
    parameter int STABLE_CYCLES = 1000,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
`ifdef PLL_FREQ_CHECK_EN
    , parameter int FREQ_WINDOW = FREQ_WINDOW_DEF
    , parameter int EXP_EDGES   = EXP_EDGES_DEF
    , parameter int FREQ_TOL    = FREQ_TOL_DEF
`endif
) (
    input  logic                 CLKI,
    input  logic                 RST,
    input  logic                 LOCK,
`ifdef PLL_FREQ_CHECK_EN
    input  logic                 CLKOP_TOG,
`endif
    output logic                 PLLRST,
    output logic                 RSTOUT,
    output logic                 READY,
    output logic                 FAULT,
    output logic [RETRIES_W-1:0] RETRIES,
    output logic [STATE_W-1:0]   STATE
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > STABLE_CYCLES)
        ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
        : ((STABLE_CYCLES > RST_CYCLES) ? STABLE_CYCLES : RST_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    function automatic logic [RETRIES_W-1:0] sat_inc(input logic [RETRIES_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t               state_q, state_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [RETRIES_W-1:0] retries_q, retries_nxt;
    logic                 pllrst_q, rstout_q, ready_q, fault_q;
    logic                 lock_s, failure, run_ok, freq_bad;

    pll_seq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (CLKI),
        .rst (RST),
        .d   (LOCK),
        .q   (lock_s)
    );

`ifdef PLL_FREQ_CHECK_EN
    localparam int WIN_W  = $clog2(FREQ_WINDOW);
    localparam int EDGE_W = $clog2(FREQ_WINDOW + 1);

    function automatic logic in_range(input logic [EDGE_W-1:0] n);
        return (int'(n) >= EXP_EDGES - FREQ_TOL) && (int'(n) <= EXP_EDGES + FREQ_TOL);
    endfunction

    logic              tog_s, tog_s_p1, tog_edge, win_done, freq_ok_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [EDGE_W-1:0] edge_cnt_q, edge_total;

    pll_seq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tog_sync (
        .clk (CLKI),
        .rst (RST),
        .d   (CLKOP_TOG),
        .q   (tog_s)
    );

    assign tog_edge   = tog_s ^ tog_s_p1;
    assign win_done   = (win_cnt_q == WIN_W'(FREQ_WINDOW - 1));
    assign edge_total = edge_cnt_q + EDGE_W'(tog_edge);

    // Free-running measurement window; freq_ok_q reflects the last complete window.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            tog_s_p1   <= 1'b0;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            freq_ok_q  <= 1'b0;
        end else begin
            tog_s_p1 <= tog_s;
            if (win_done) begin
                win_cnt_q  <= '0;
                edge_cnt_q <= '0;
                freq_ok_q  <= in_range(edge_total);
            end else begin
                win_cnt_q  <= win_cnt_q + 1'b1;
                edge_cnt_q <= edge_total;
            end
        end
    end

    assign run_ok   = freq_ok_q;
    assign freq_bad = win_done && !in_range(edge_total);
`else
    assign run_ok   = 1'b1;
    assign freq_bad = 1'b0;
`endif

    always_ff @(posedge CLKI) begin
        if (RST) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            retries_q <= '0;
            pllrst_q  <= 1'b1;
            rstout_q  <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            retries_q <= retries_nxt;
            pllrst_q  <= (state_nxt == S_PLLRST) || (state_nxt == S_FAULT);
            rstout_q  <= (state_nxt != S_RUN);
            ready_q   <= (state_nxt == S_RUN);
            fault_q   <= (state_nxt == S_FAULT);
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        retries_nxt = retries_q;
        failure     = 1'b0;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = S_WAITLOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            S_WAITLOCK: begin
                if (lock_s) begin
                    state_nxt = S_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    failure = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                // A lock glitch here only restarts the wait; it is not a failed attempt.
                if (freq_bad) begin
                    failure = 1'b1;
                end else if (!lock_s) begin
                    state_nxt = S_WAITLOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    if (run_ok) begin
                        state_nxt   = S_RUN;
                        cnt_nxt     = '0;
                        retries_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s || freq_bad) begin
                    failure = 1'b1;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_PLLRST;
                cnt_nxt   = '0;
            end
        endcase

        if (failure) begin
            cnt_nxt = '0;
            if (int'(retries_q) < MAX_RETRIES) begin
                retries_nxt = sat_inc(retries_q);
                state_nxt   = S_PLLRST;
            end else begin
                state_nxt = S_FAULT;
            end
        end
    end

    assign PLLRST  = pllrst_q;
    assign RSTOUT  = rstout_q;
    assign READY   = ready_q;
    assign FAULT   = fault_q;
    assign RETRIES = retries_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with hand-computed cycle expectations.
// Frequency-check scenarios run only when PLL_FREQ_CHECK_EN is defined.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    logic       CLKI = 1'b0;
    logic       RST  = 1'b1;
    logic       LOCK = 1'b0;
    logic       PLLRST, RSTOUT, READY, FAULT;
    logic [3:0] RETRIES;
    logic [2:0] STATE;
`ifdef PLL_FREQ_CHECK_EN
    logic       CLKOP_TOG = 1'b0;
    int         edges_per_win = 0;
    int         acc = 0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLKI = ~CLKI;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .SYNC_STAGES   (2)
    ) dut (
        .CLKI      (CLKI),
        .RST       (RST),
        .LOCK      (LOCK),
`ifdef PLL_FREQ_CHECK_EN
        .CLKOP_TOG (CLKOP_TOG),
`endif
        .PLLRST    (PLLRST),
        .RSTOUT    (RSTOUT),
        .READY     (READY),
        .FAULT     (FAULT),
        .RETRIES   (RETRIES),
        .STATE     (STATE)
    );

`ifdef PLL_FREQ_CHECK_EN
    // Toggle CLKOP_TOG so that edges_per_win edges land in each 1024-cycle window.
    always @(posedge CLKI) begin
        #2;
        acc = acc + edges_per_win;
        if (acc >= FREQ_WINDOW_DEF) begin
            acc = acc - FREQ_WINDOW_DEF;
            CLKOP_TOG = ~CLKOP_TOG;
        end
    end
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLKI);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pllrst"},  PLLRST,  1);
        chk({tag, "_rstout"},  RSTOUT,  1);
        chk({tag, "_ready"},   READY,   0);
        chk({tag, "_fault"},   FAULT,   0);
        chk({tag, "_retries"}, RETRIES, 0);
        chk({tag, "_state"},   STATE,   0);
    endtask

    // Leaves the bench just after the last reset edge; the next tick() is edge e0.
    task automatic do_reset();
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
    endtask

    initial begin
        int lat;
        logic ready_seen;

`ifndef PLL_FREQ_CHECK_EN
        // 1: lock already high
        LOCK = 1'b1;
        do_reset();
        chk_reset_vals("t1_rst");
        for (int e = 0; e <= 12; e++) begin
            tick();
            if (e == 2)  chk("t1_pllrst_e2", PLLRST, 1);
            if (e == 3)  begin chk("t1_pllrst_e3", PLLRST, 0); chk("t1_wait_e3", STATE, 1); end
            if (e == 4)  chk("t1_stable_e4", STATE, 2);
            if (e == 11) begin chk("t1_rstout_e11", RSTOUT, 1); chk("t1_ready_e11", READY, 0); end
            if (e == 12) begin
                chk("t1_rstout_e12", RSTOUT, 0);
                chk("t1_ready_e12", READY, 1);
                chk("t1_state_e12", STATE, 3);
                chk("t1_retries_e12", RETRIES, 0);
            end
        end

        // 3: one-cycle lock drop in RUN
        LOCK = 1'b0;
        tick();
        LOCK = 1'b1;
        tick();
        chk("t3_ready_hold", READY, 1);
        tick();
        chk("t3_ready_drop", READY, 0);
        chk("t3_rstout_rise", RSTOUT, 1);
        chk("t3_retries", RETRIES, 1);
        chk("t3_state", STATE, 0);
        chk("t3_pllrst", PLLRST, 1);
        repeat (12) tick();
        chk("t3_ready_before", READY, 0);
        tick();
        chk("t3_ready_again", READY, 1);
        chk("t3_retries_clr", RETRIES, 0);

        // 2: lock never arrives
        LOCK = 1'b0;
        do_reset();
        for (int e = 0; e <= 71; e++) begin
            tick();
            if (e == 3)  chk("t2_pllrst_e3", PLLRST, 0);
            if (e == 22) begin chk("t2_state_e22", STATE, 1); chk("t2_retries_e22", RETRIES, 0); end
            if (e == 23) begin chk("t2_pllrst_e23", PLLRST, 1); chk("t2_retries_e23", RETRIES, 1); end
            if (e == 26) chk("t2_pllrst_e26", PLLRST, 1);
            if (e == 27) chk("t2_pllrst_e27", PLLRST, 0);
            if (e == 47) begin chk("t2_retries_e47", RETRIES, 2); chk("t2_pllrst_e47", PLLRST, 1); end
            if (e == 70) begin chk("t2_fault_e70", FAULT, 0); chk("t2_state_e70", STATE, 1); end
            if (e == 71) begin
                chk("t2_fault_e71", FAULT, 1);
                chk("t2_state_e71", STATE, 4);
                chk("t2_pllrst_e71", PLLRST, 1);
                chk("t2_retries_e71", RETRIES, 2);
            end
        end
        LOCK = 1'b1;
        repeat (30) tick();
        chk("t2_fault_sticky", FAULT, 1);
        chk("t2_rstout_fault", RSTOUT, 1);

        // 5b: reset out of FAULT
        RST = 1'b1;
        tick();
        chk_reset_vals("t5_fault_rst");
        RST = 1'b0;
        repeat (13) tick();
        chk("t5_fault_rerun_ready", READY, 1);
        chk("t5_fault_rerun_fault", FAULT, 0);

        // 4: chatter every 5th cycle
        LOCK = 1'b1;
        do_reset();
        ready_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            LOCK = (i % 5 == 4) ? 1'b0 : 1'b1;
            tick();
            if (READY) ready_seen = 1'b1;
        end
        chk("t4_no_run", ready_seen, 0);
        chk("t4_retries", RETRIES, 0);
        LOCK = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (READY && lat == 0) lat = n;
        end
        chk("t4_run_latency", lat, 11);

        // 5a: reset during STABLE
        do_reset();
        repeat (8) tick();
        chk("t5_in_stable", STATE, 2);
        RST = 1'b1;
        tick();
        chk_reset_vals("t5_stable_rst");
        RST = 1'b0;
        repeat (12) tick();
        chk("t5_rerun_ready_e11", READY, 0);
        tick();
        chk("t5_rerun_ready_e12", READY, 1);
`else
        // 6a: 150 edges per window -> never runs, ends in FAULT
        LOCK = 1'b1;
        edges_per_win = 150;
        do_reset();
        chk_reset_vals("t6_rst");
        ready_seen = 1'b0;
        for (int n = 0; n < 5000 && !FAULT; n++) begin
            tick();
            if (READY) ready_seen = 1'b1;
        end
        chk("t6_slow_fault", FAULT, 1);
        chk("t6_slow_no_run", ready_seen, 0);
        chk("t6_slow_retries", RETRIES, 2);

        // 6b: 160 edges per window -> RUN after first window
        edges_per_win = 160;
        do_reset();
        lat = 0;
        for (int n = 1; n <= 3000 && lat == 0; n++) begin
            tick();
            if (READY) lat = n;
        end
        chk("t6_ok_reached", (lat > 1000 && lat < 1100) ? 1 : 0, 1);
        chk("t6_ok_retries", RETRIES, 0);
        chk("t6_ok_fault", FAULT, 0);
        repeat (1100) tick();
        chk("t6_ok_stays_run", READY, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
